// File: rtl/mkio_pkg.sv
// Shared types and constants for the MKIO dual-redundant bus arbiter.
package mkio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } bus_state_e;

  localparam int SYNC_MIN_DEF = 40;
  localparam int DLY_DEF      = 96;
  localparam int IDLE_TO_DEF  = 480;

  localparam logic [1:0] LINE_HI = 2'b10;
  localparam logic [1:0] LINE_LO = 2'b01;

  // 00 and 11 both mean no differential drive on the pair.
  function automatic logic line_idle(input logic [1:0] line);
    return (line == 2'b00) || (line == 2'b11);
  endfunction

endpackage

// File: rtl/mkio_sync_det.sv
// Command-sync detector for one channel: a long 10 run followed by a long 01 run.
// cmd_sync is combinational and fires once, on the SYNC_MIN-th 01 clock.
module mkio_sync_det
  import mkio_pkg::*;
#(
  parameter int SYNC_MIN = SYNC_MIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] line,
  output logic       cmd_sync
);

  localparam logic [6:0] MIN_C = 7'(SYNC_MIN);

  logic [6:0] hi_cnt;
  logic [6:0] lo_cnt;
  logic       armed;
  logic       is_hi;
  logic       is_lo;

  assign is_hi    = (line == LINE_HI);
  assign is_lo    = (line == LINE_LO);
  assign cmd_sync = armed && is_lo && ((lo_cnt + 7'd1) == MIN_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      armed  <= 1'b0;
    end else begin
      if (is_hi) begin
        hi_cnt <= (hi_cnt == 7'h7f) ? hi_cnt : hi_cnt + 7'd1;
      end else begin
        hi_cnt <= '0;
      end

      // hi_cnt is nonzero only if the previous clock was 10, so this is the 10->01 edge.
      if (armed) begin
        if (is_lo && !cmd_sync) begin
          lo_cnt <= lo_cnt + 7'd1;
        end else begin
          armed  <= 1'b0;
          lo_cnt <= '0;
        end
      end else if (is_lo && (hi_cnt >= MIN_C)) begin
        armed  <= 1'b1;
        lo_cnt <= 7'd1;
      end
    end
  end

endmodule

// File: rtl/mkio_bus_arbiter.sv
// MKIO remote-terminal bus arbiter: locks the codec onto channel A or B and gates TX.
// Define MKIO_SUPERSEDE_EN to let a command on the other bus abort and switch the lock.
module mkio_bus_arbiter
  import mkio_pkg::*;
#(
  parameter int SYNC_MIN = SYNC_MIN_DEF,
  parameter int DLY      = DLY_DEF,
  parameter int IDLE_TO  = IDLE_TO_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DI1A,
  input  logic       DI0A,
  input  logic       DI1B,
  input  logic       DI0B,
  output logic       DO1A,
  output logic       DO0A,
  output logic       DO1B,
  output logic       DO0B,
  output logic       RX_STROB_A,
  output logic       RX_STROB_B,
  output logic       TX_INHIBIT_A,
  output logic       TX_INHIBIT_B,
  output logic       dec_di1,
  output logic       dec_di0,
  input  logic       enc_do1,
  input  logic       enc_do0,
  input  logic       enc_busy,
  output logic       core_abort,
  output logic       bus_sel,
  output logic       bus_locked,
  output logic [1:0] dbg_state
);

  localparam logic [8:0] IDLE_LAST = 9'(IDLE_TO - 1);

  logic [1:0] line_a;
  logic [1:0] line_b;
  logic       cmd_sync_a;
  logic       cmd_sync_b;

  assign line_a = {DI1A, DI0A};
  assign line_b = {DI1B, DI0B};

  mkio_sync_det #(.SYNC_MIN(SYNC_MIN)) u_det_a (
    .clk      (clk),
    .reset    (reset),
    .line     (line_a),
    .cmd_sync (cmd_sync_a)
  );

  mkio_sync_det #(.SYNC_MIN(SYNC_MIN)) u_det_b (
    .clk      (clk),
    .reset    (reset),
    .line     (line_b),
    .cmd_sync (cmd_sync_b)
  );

  // The decoder sees the stream DLY clocks late, so the lock decision beats the sync.
  logic [DLY-1:0][1:0] dly_a;
  logic [DLY-1:0][1:0] dly_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_a <= '0;
      dly_b <= '0;
    end else begin
      dly_a <= {dly_a[DLY-2:0], line_a};
      dly_b <= {dly_b[DLY-2:0], line_b};
    end
  end

  logic take_a;
  logic take_b;

`ifdef MKIO_SUPERSEDE_EN
  assign take_a = cmd_sync_a;
  assign take_b = cmd_sync_b;
`else
  assign take_a = 1'b0;
  assign take_b = 1'b0;
`endif

  bus_state_e state;
  bus_state_e state_nxt;
  logic       abort_nxt;
  logic [8:0] idle_cnt;
  logic [1:0] own_line;
  logic       own_quiet;
  logic       unlock;
  logic       tx_a;
  logic       tx_b;

  assign own_line  = (state == ST_LOCK_B) ? line_b : line_a;
  assign own_quiet = line_idle(own_line) && !enc_busy;
  assign unlock    = own_quiet && (idle_cnt == IDLE_LAST);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_sync_a) begin
          state_nxt = ST_LOCK_A;
        end else if (cmd_sync_b) begin
          state_nxt = ST_LOCK_B;
        end
      end
      ST_LOCK_A: begin
        if (take_b) begin
          state_nxt = ST_LOCK_B;
          abort_nxt = 1'b1;
        end else if (unlock) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCK_B: begin
        if (take_a) begin
          state_nxt = ST_LOCK_A;
          abort_nxt = 1'b1;
        end else if (unlock) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so a supersede kills the old bus on the abort edge.
  assign tx_a = (state_nxt == ST_LOCK_A) && enc_busy;
  assign tx_b = (state_nxt == ST_LOCK_B) && enc_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idle_cnt     <= '0;
      core_abort   <= 1'b0;
      bus_sel      <= 1'b0;
      bus_locked   <= 1'b0;
      DO1A         <= 1'b0;
      DO0A         <= 1'b0;
      DO1B         <= 1'b0;
      DO0B         <= 1'b0;
      TX_INHIBIT_A <= 1'b1;
      TX_INHIBIT_B <= 1'b1;
      RX_STROB_A   <= 1'b0;
      RX_STROB_B   <= 1'b0;
      dec_di1      <= 1'b0;
      dec_di0      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == ST_IDLE) || !own_quiet) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 9'd1;
      end
      core_abort   <= abort_nxt;
      bus_sel      <= (state_nxt == ST_LOCK_B);
      bus_locked   <= (state_nxt != ST_IDLE);
      DO1A         <= tx_a & enc_do1;
      DO0A         <= tx_a & enc_do0;
      DO1B         <= tx_b & enc_do1;
      DO0B         <= tx_b & enc_do0;
      TX_INHIBIT_A <= !tx_a;
      TX_INHIBIT_B <= !tx_b;
      RX_STROB_A   <= !tx_a;
      RX_STROB_B   <= !tx_b;
      case (state_nxt)
        ST_LOCK_A: {dec_di1, dec_di0} <= dly_a[DLY-1];
        ST_LOCK_B: {dec_di1, dec_di0} <= dly_b[DLY-1];
        default:   {dec_di1, dec_di0} <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_mkio_bus_arbiter.sv
// Bench for mkio_bus_arbiter: random MKIO words against a pattern-matching reference model.
`timescale 1ns/1ps
module tb_mkio_bus_arbiter;

  localparam int SYNC_MIN  = 40;
  localparam int DLY       = 96;
  localparam int IDLE_TO   = 480;
  localparam int HALF      = 16;
  localparam int SYNC_HALF = 48;
  localparam int WORD_LEN  = 2 * SYNC_HALF + 17 * 2 * HALF;
`ifdef MKIO_SUPERSEDE_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic DI1A = 1'b0, DI0A = 1'b0, DI1B = 1'b0, DI0B = 1'b0;
  logic enc_do1 = 1'b0, enc_do0 = 1'b0, enc_busy = 1'b0;
  logic DO1A, DO0A, DO1B, DO0B;
  logic RX_STROB_A, RX_STROB_B, TX_INHIBIT_A, TX_INHIBIT_B;
  logic dec_di1, dec_di0, core_abort, bus_sel, bus_locked;
  logic [1:0] dbg_state;

  mkio_bus_arbiter #(.SYNC_MIN(SYNC_MIN), .DLY(DLY), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .reset(reset),
    .DI1A(DI1A), .DI0A(DI0A), .DI1B(DI1B), .DI0B(DI0B),
    .DO1A(DO1A), .DO0A(DO0A), .DO1B(DO1B), .DO0B(DO0B),
    .RX_STROB_A(RX_STROB_A), .RX_STROB_B(RX_STROB_B),
    .TX_INHIBIT_A(TX_INHIBIT_A), .TX_INHIBIT_B(TX_INHIBIT_B),
    .dec_di1(dec_di1), .dec_di0(dec_di0),
    .enc_do1(enc_do1), .enc_do0(enc_do0), .enc_busy(enc_busy),
    .core_abort(core_abort), .bus_sel(bus_sel), .bus_locked(bus_locked),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 locked A, 2 locked B.
  logic [1:0] hist_a[$], hist_b[$];
  logic [1:0] plan_a[$], plan_b[$];
  int         mst  = 0;
  int         qrun = 0;
  bit         exp_locked, exp_sel, exp_abort, exp_tx_a, exp_tx_b;
  logic [1:0] exp_do_a, exp_do_b, exp_dec;

  function automatic logic [1:0] hist_at(input int ch, input int idx);
    if (idx < 0) return 2'b00;
    return (ch == 0) ? hist_a[idx] : hist_b[idx];
  endfunction

  // A command sync ends at clock m if the last SYNC_MIN samples are 01 and the SYNC_MIN before are 10.
  function automatic bit pat_sync(input int ch, input int m);
    if (m < 2 * SYNC_MIN - 1) return 1'b0;
    for (int i = 0; i < SYNC_MIN; i++)
      if (hist_at(ch, m - i) != 2'b01) return 1'b0;
    for (int i = SYNC_MIN; i < 2 * SYNC_MIN; i++)
      if (hist_at(ch, m - i) != 2'b10) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    hist_a.delete(); hist_b.delete(); plan_a.delete(); plan_b.delete();
    mst = 0; qrun = 0;
  endtask

  task automatic tick();
    int m, nxt;
    bit sa, sb, quiet;
    logic [1:0] own;
    @(posedge clk);
    hist_a.push_back({DI1A, DI0A});
    hist_b.push_back({DI1B, DI0B});
    m  = hist_a.size() - 1;
    sa = pat_sync(0, m);
    sb = pat_sync(1, m);
    nxt = mst;
    exp_abort = 1'b0;
    if (mst == 0) begin
      if (sa) nxt = 1;
      else if (sb) nxt = 2;
    end else begin
      own   = (mst == 1) ? hist_a[m] : hist_b[m];
      quiet = (own == 2'b00 || own == 2'b11) && !enc_busy;
      if (SUP && ((mst == 1 && sb) || (mst == 2 && sa))) begin
        nxt = 3 - mst;
        exp_abort = 1'b1;
      end else if (quiet) begin
        qrun++;
        if (qrun >= IDLE_TO) nxt = 0;
      end else begin
        qrun = 0;
      end
    end
    if (nxt != mst) qrun = 0;
    exp_tx_a   = (nxt == 1) && enc_busy;
    exp_tx_b   = (nxt == 2) && enc_busy;
    exp_do_a   = exp_tx_a ? {enc_do1, enc_do0} : 2'b00;
    exp_do_b   = exp_tx_b ? {enc_do1, enc_do0} : 2'b00;
    exp_dec    = (nxt == 1) ? hist_at(0, m - DLY) : (nxt == 2) ? hist_at(1, m - DLY) : 2'b00;
    exp_locked = (nxt != 0);
    exp_sel    = (nxt == 2);
    mst = nxt;
    #1;
  endtask

  task automatic push(input int ch, input logic [1:0] v);
    if (ch == 0) plan_a.push_back(v);
    else plan_b.push_back(v);
  endtask

  task automatic add_idle(input int ch, input int n);
    for (int i = 0; i < n; i++) push(ch, 2'b00);
  endtask

  task automatic add_word(input int ch, input bit cmd, input logic [15:0] data);
    logic [16:0] bits;
    bits = {data, ~^data};
    for (int i = 0; i < SYNC_HALF; i++) push(ch, cmd ? 2'b10 : 2'b01);
    for (int i = 0; i < SYNC_HALF; i++) push(ch, cmd ? 2'b01 : 2'b10);
    for (int b = 16; b >= 0; b--) begin
      for (int i = 0; i < HALF; i++) push(ch, bits[b] ? 2'b10 : 2'b01);
      for (int i = 0; i < HALF; i++) push(ch, bits[b] ? 2'b01 : 2'b10);
    end
  endtask

  task automatic cycle();
    if (plan_a.size() > 0) {DI1A, DI0A} = plan_a.pop_front();
    else {DI1A, DI0A} = 2'b00;
    if (plan_b.size() > 0) {DI1B, DI0B} = plan_b.pop_front();
    else {DI1B, DI0B} = 2'b00;
    if (enc_busy) {enc_do1, enc_do0} = 2'($urandom_range(0, 3));
    else {enc_do1, enc_do0} = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({DO1A, DO0A, DO1B, DO0B} !== 4'b0000) begin bad++; $display("FAIL rst_do: got %b want 0000", {DO1A, DO0A, DO1B, DO0B}); end
    total++; if ({TX_INHIBIT_A, TX_INHIBIT_B} !== 2'b11) begin bad++; $display("FAIL rst_inhibit: got %b want 11", {TX_INHIBIT_A, TX_INHIBIT_B}); end
    total++; if ({RX_STROB_A, RX_STROB_B} !== 2'b00) begin bad++; $display("FAIL rst_strob: got %b want 00", {RX_STROB_A, RX_STROB_B}); end
    total++; if ({dec_di1, dec_di0} !== 2'b00) begin bad++; $display("FAIL rst_dec: got %b want 00", {dec_di1, dec_di0}); end
    total++; if ({core_abort, bus_sel, bus_locked} !== 3'b000) begin bad++; $display("FAIL rst_ctrl: got %b want 000", {core_abort, bus_sel, bus_locked}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
    model_clear();
    cycle();
    total++; if ({RX_STROB_A, RX_STROB_B} !== 2'b11) begin bad++; $display("FAIL strob_rise: got %b want 11", {RX_STROB_A, RX_STROB_B}); end
    total++; if ({TX_INHIBIT_A, TX_INHIBIT_B} !== 2'b11) begin bad++; $display("FAIL idle_inhibit: got %b want 11", {TX_INHIBIT_A, TX_INHIBIT_B}); end
  endtask

  task automatic test_command_a();
    int lock_at = -1;
    add_word(0, 1'b1, 16'($urandom));
    for (int n = 0; n < WORD_LEN + IDLE_TO + 10; n++) begin
      cycle();
      if (lock_at < 0 && bus_locked === 1'b1) lock_at = n + 1;
      total++; if ({bus_locked, bus_sel} !== {exp_locked, exp_sel}) begin bad++; $display("FAIL cmd_a_lock n=%0d: got %b want %b", n, {bus_locked, bus_sel}, {exp_locked, exp_sel}); end
      total++; if ({dec_di1, dec_di0} !== exp_dec) begin bad++; $display("FAIL cmd_a_dec n=%0d: got %b want %b", n, {dec_di1, dec_di0}, exp_dec); end
      total++; if ({DO1B, DO0B, TX_INHIBIT_B} !== 3'b001) begin bad++; $display("FAIL cmd_a_b_quiet n=%0d: got %b want 001", n, {DO1B, DO0B, TX_INHIBIT_B}); end
      if (n == DLY - 1 || n == DLY) begin
        total++; if ({dec_di1, dec_di0} !== ((n == DLY) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL dly_edge n=%0d: got %b", n, {dec_di1, dec_di0}); end
      end
    end
    total++; if (lock_at < 1 || lock_at > 89) begin bad++; $display("FAIL lock_latency: got %0d want 1..89", lock_at); end
    total++; if (bus_locked !== 1'b0) begin bad++; $display("FAIL cmd_a_unlock: got %b want 0", bus_locked); end
  endtask

  task automatic test_data_sync_b();
    add_word(1, 1'b0, {1'b0, 15'($urandom)});
    for (int n = 0; n < WORD_LEN + 20; n++) begin
      cycle();
      total++; if ({bus_locked, dec_di1, dec_di0} !== 3'b000) begin bad++; $display("FAIL data_sync_b n=%0d: got %b want 000", n, {bus_locked, dec_di1, dec_di0}); end
    end
  endtask

  task automatic test_simultaneous();
    add_word(0, 1'b1, 16'($urandom));
    add_word(1, 1'b1, 16'($urandom));
    for (int n = 0; n < WORD_LEN + IDLE_TO + 10; n++) begin
      cycle();
      total++; if ({bus_locked, bus_sel} !== {exp_locked, exp_sel}) begin bad++; $display("FAIL simul_lock n=%0d: got %b want %b", n, {bus_locked, bus_sel}, {exp_locked, exp_sel}); end
      if (n == SYNC_HALF + SYNC_MIN - 1) begin
        total++; if ({bus_locked, bus_sel} !== 2'b10) begin bad++; $display("FAIL simul_a_wins: got %b want 10", {bus_locked, bus_sel}); end
      end
    end
  endtask

  task automatic test_tx_supersede();
    int aborts = 0;
    int sw = 200 + SYNC_HALF + SYNC_MIN - 1;
    add_word(0, 1'b1, 16'($urandom));
    add_idle(1, 200);
    add_word(1, 1'b1, 16'($urandom));
    for (int n = 0; n < 1500; n++) begin
      if (n == 100) enc_busy = 1'b1;
      if (n == 420) enc_busy = 1'b0;
      cycle();
      if (core_abort === 1'b1) aborts++;
      total++; if ({DO1A, DO0A, DO1B, DO0B} !== {exp_do_a, exp_do_b}) begin bad++; $display("FAIL tx_do n=%0d: got %b want %b", n, {DO1A, DO0A, DO1B, DO0B}, {exp_do_a, exp_do_b}); end
      total++; if ({TX_INHIBIT_A, TX_INHIBIT_B, RX_STROB_A, RX_STROB_B} !== {!exp_tx_a, !exp_tx_b, !exp_tx_a, !exp_tx_b}) begin bad++; $display("FAIL tx_gate n=%0d: got %b", n, {TX_INHIBIT_A, TX_INHIBIT_B, RX_STROB_A, RX_STROB_B}); end
      total++; if ({core_abort, bus_locked, bus_sel} !== {exp_abort, exp_locked, exp_sel}) begin bad++; $display("FAIL tx_ctrl n=%0d: got %b want %b", n, {core_abort, bus_locked, bus_sel}, {exp_abort, exp_locked, exp_sel}); end
      if (n == 150) begin
        total++; if ({TX_INHIBIT_A, RX_STROB_A} !== 2'b00) begin bad++; $display("FAIL tx_a_active: got %b want 00", {TX_INHIBIT_A, RX_STROB_A}); end
      end
      if (n == sw) begin
        total++; if ({core_abort, bus_sel, TX_INHIBIT_A} !== {SUP, SUP, SUP}) begin bad++; $display("FAIL supersede_edge: got %b want %b", {core_abort, bus_sel, TX_INHIBIT_A}, {SUP, SUP, SUP}); end
      end
    end
    total++; if (aborts !== (SUP ? 1 : 0)) begin bad++; $display("FAIL abort_count: got %0d want %0d", aborts, SUP ? 1 : 0); end
    total++; if (bus_locked !== 1'b0) begin bad++; $display("FAIL tx_final_idle: got %b want 0", bus_locked); end
  endtask

  task automatic test_idle_timeout();
    int pulse = WORD_LEN + IDLE_TO - 1;
    add_word(0, 1'b1, 16'($urandom));
    add_idle(0, IDLE_TO - 1);
    push(0, 2'b10);
    add_idle(0, IDLE_TO + 5);
    for (int n = 0; n < pulse + IDLE_TO + 5; n++) begin
      cycle();
      total++; if (bus_locked !== exp_locked) begin bad++; $display("FAIL idle_model n=%0d: got %b want %b", n, bus_locked, exp_locked); end
      if (n == pulse - 1 || n == pulse || n == pulse + IDLE_TO - 1) begin
        total++; if (bus_locked !== 1'b1) begin bad++; $display("FAIL idle_hold n=%0d: got %b want 1", n, bus_locked); end
      end
      if (n == pulse + IDLE_TO) begin
        total++; if (bus_locked !== 1'b0) begin bad++; $display("FAIL idle_release n=%0d: got %b want 0", n, bus_locked); end
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    add_word(1, 1'b1, 16'($urandom));
    for (int n = 0; n < 150; n++) begin
      if (n == 100) enc_busy = 1'b1;
      cycle();
    end
    total++; if ({bus_locked, bus_sel, TX_INHIBIT_B} !== 3'b110) begin bad++; $display("FAIL b_tx_before_reset: got %b want 110", {bus_locked, bus_sel, TX_INHIBIT_B}); end
    #3 reset = 1'b1;
    #1;
    total++; if ({DO1A, DO0A, DO1B, DO0B, dec_di1, dec_di0} !== 6'b0) begin bad++; $display("FAIL async_rst_data: got %b want 0", {DO1A, DO0A, DO1B, DO0B, dec_di1, dec_di0}); end
    total++; if ({TX_INHIBIT_A, TX_INHIBIT_B, RX_STROB_A, RX_STROB_B} !== 4'b1100) begin bad++; $display("FAIL async_rst_gate: got %b want 1100", {TX_INHIBIT_A, TX_INHIBIT_B, RX_STROB_A, RX_STROB_B}); end
    total++; if ({core_abort, bus_sel, bus_locked} !== 3'b000) begin bad++; $display("FAIL async_rst_ctrl: got %b want 000", {core_abort, bus_sel, bus_locked}); end
    enc_busy = 1'b0;
    {DI1A, DI0A, DI1B, DI0B} = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    add_word(0, 1'b1, 16'($urandom));
    for (int n = 0; n < 200; n++) begin
      cycle();
      total++; if ({bus_locked, bus_sel, dec_di1, dec_di0} !== {exp_locked, exp_sel, exp_dec}) begin bad++; $display("FAIL relock_a n=%0d: got %b want %b", n, {bus_locked, bus_sel, dec_di1, dec_di0}, {exp_locked, exp_sel, exp_dec}); end
      if (n == SYNC_HALF + SYNC_MIN - 1) begin
        total++; if ({bus_locked, bus_sel} !== 2'b10) begin bad++; $display("FAIL relock_edge: got %b want 10", {bus_locked, bus_sel}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_command_a();
    test_data_sync_b();
    test_simultaneous();
    test_tx_supersede();
    test_idle_timeout();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mkio_bus_arbiter.md
# mkio_bus_arbiter

Dual-redundant bus arbiter for the MKIO remote terminal. It sits between the channel A/B transceiver pins and the single Manchester decoder/encoder core. It detects command syncs on both channels, locks the core onto one bus, and routes delayed receive data to the decoder. It gates encoder output and transmitter inhibits to the locked bus only, and handles superseding commands on the other bus by aborting and switching.

## Interface
Parameters:
- SYNC_MIN, 40: minimum clocks per sync half (1.5 µs nominal = 48 clk at 32 MHz).
- DLY, 96: receive delay line depth in clocks.
- IDLE_TO, 480: consecutive idle clocks on the locked bus before unlock (15 µs).

Ports:
- clk  in  1  system clock, 32 MHz.
- reset  in  1  asynchronous, active-high.
- DI1A, DI0A  in  1 each  channel A receive pair.
- DI1B, DI0B  in  1 each  channel B receive pair.
- DO1A, DO0A  out  1 each  channel A transmit pair.
- DO1B, DO0B  out  1 each  channel B transmit pair.
- RX_STROB_A, RX_STROB_B  out  1 each  receiver enables.
- TX_INHIBIT_A, TX_INHIBIT_B  out  1 each  transmitter inhibits, active-high.
- dec_di1, dec_di0  out  1 each  delayed receive pair to the decoder.
- enc_do1, enc_do0  in  1 each  encoder output pair.
- enc_busy  in  1  encoder is transmitting.
- core_abort  out  1  one-cycle pulse when a message is superseded.
- bus_sel  out  1  locked bus: 0 = A, 1 = B.
- bus_locked  out  1  arbiter is in a LOCK state.

## Operation
- Per-channel sync detector runs on raw inputs:
  - Counts consecutive clocks of {DI1,DI0}=10 into hi_cnt (7 bit, saturating).
  - On a 10→01 transition with hi_cnt ≥ SYNC_MIN, arms and counts 01 clocks.
  - lo count reaching SYNC_MIN pulses cmd_sync once.
  - 00/11, or a return to 10 before that point, disarms.
  - Data syncs (01 first) and data bits (≤32 clk runs) never fire it.
- Per-channel DLY-deep shift register of {DI1,DI0}. The decoder sees the delayed stream, so a bus switch at sync detection precedes the delayed sync start.
- FSM states ST_IDLE, ST_LOCK_A, ST_LOCK_B:
  - ST_IDLE: cmd_sync_a goes to LOCK_A; otherwise cmd_sync_b goes to LOCK_B. If both fire in the same cycle, A wins.
  - ST_LOCK_x: cmd_sync on own bus has no effect. cmd_sync on the other bus pulses core_abort and moves to LOCK_other (supersede).
  - ST_LOCK_x, unlock: idle counter (9 bit) counts clocks where own raw line is 00/11 and enc_busy=0, and clears on any activity or enc_busy. Reaching IDLE_TO moves to ST_IDLE.
- Routing:
  - dec_di* = delayed pair of the locked bus; 00 in ST_IDLE.
  - DO1x/DO0x = enc_do* only when locked to x and enc_busy=1; else 00.
  - TX_INHIBIT_x = 0 only when locked to x and enc_busy=1.
  - RX_STROB_x = 1 except on the bus currently transmitting.

## Timing
- All outputs registered.
- Reset values: DO* 0; TX_INHIBIT_* 1; RX_STROB_* 0; dec_di* 0; core_abort 0; bus_sel 0; bus_locked 0. Delay lines and counters clear.
- RX_STROB_* rise on the first clock after reset deassertion.
- DI → dec_di latency: exactly DLY+1 clocks.
- cmd_sync is internal and combinational. State change, core_abort and bus_sel update on the next clock.
- enc_do → DO latency: 1 clock. On supersede during transmit, DO of the old bus is 00 and its TX_INHIBIT is 1 from the same edge that raises core_abort.
- Reset mid-message forces all outputs to reset values immediately (asynchronous).

## Configuration
- MKIO_SUPERSEDE_EN defined: supersede behaviour as above.
- MKIO_SUPERSEDE_EN undefined:
  - Other-bus cmd_sync is ignored while locked.
  - core_abort is tied 0.
  - Switching occurs only via ST_IDLE.

## Structure
- Package mkio_pkg holds:
  - bus_state_e enum (ST_IDLE, ST_LOCK_A, ST_LOCK_B).
  - Default constants SYNC_MIN_DEF, DLY_DEF, IDLE_TO_DEF.
  - Line-state localparams LINE_HI=2'b10, LINE_LO=2'b01.
- Sub-module mkio_sync_det, instantiated once per channel.
- Delay lines, FSM and output muxing live in the top.

## Test plan
- Command word (sync 111000, 1 µs bits, 500 ns half-bits) on A at t0 → bus_locked=1, bus_sel=0 within 89 clk of sync start; dec_di replays A with exactly DLY+1 clk delay; B pins stay 00, TX_INHIBIT_B=1.
- Data-sync word only on B while idle → no lock, dec_di stays 00.
- Command syncs on A and B aligned to the same clock → LOCK_A, bus_sel=0.
- Locked A, raise enc_busy with enc_do toggling → DO1A/DO0A follow with 1 clk lag, TX_INHIBIT_A=0, RX_STROB_A=0; then command on B → one-cycle core_abort, bus_sel=1, DO1A/DO0A=00, TX_INHIBIT_A=1. Without MKIO_SUPERSEDE_EN, the lock stays on A and core_abort never pulses.
- Locked A, line idle 479 clk then a pulse → still locked; then 480 idle clk with enc_busy=0 → ST_IDLE.
- Assert reset during a B transmission → all outputs take reset values asynchronously; after release, a fresh command on A locks normally.
